// File: rtl/mem_arbiter_np.sv
// N-requester arbiter in front of a true-dual-port SRAM: per-requester queues,
// fixed-priority or round-robin dual grant, starvation promotion, collision guard.
module mem_arbiter_np #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int N_REQ        = 4,
  parameter int QDEPTH       = 2,
  parameter int RR_EN        = 0,
  parameter int STARVE_LIMIT = 8,
  parameter int RD_LAT       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_en,
  input  logic [N_REQ-1:0]              req_wr,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0]   rsp_data,
  output logic [ADDR_WIDTH-1:0]         mem_addr_a,
  output logic [ADDR_WIDTH-1:0]         mem_addr_b,
  output logic [DATA_WIDTH-1:0]         mem_data_a,
  output logic [DATA_WIDTH-1:0]         mem_data_b,
  output logic                          mem_we_a,
  output logic                          mem_we_b,
  input  logic [DATA_WIDTH-1:0]         mem_q_a,
  input  logic [DATA_WIDTH-1:0]         mem_q_b
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int GW = $clog2(STARVE_LIMIT + 1);

  logic                  q_wr   [N_REQ][QDEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [N_REQ][QDEPTH];
  logic [DATA_WIDTH-1:0] q_data [N_REQ][QDEPTH];
  logic [PW-1:0]         wptr [N_REQ];
  logic [PW-1:0]         rptr [N_REQ];
  logic [CW-1:0]         cnt  [N_REQ];
  logic [GW-1:0]         age  [N_REQ];
  logic [IW-1:0]         rr;

  logic                  head_wr   [N_REQ];
  logic [ADDR_WIDTH-1:0] head_addr [N_REQ];
  logic [DATA_WIDTH-1:0] head_data [N_REQ];
  logic [N_REQ-1:0]      full, pend, starved, push, pop;

  logic [IW-1:0] ord [N_REQ];
  logic [IW:0]   pos;
  logic [IW-1:0] idx, cur, ga, gb;
  logic          ga_v, gb_v;

  logic [RD_LAT-1:0] tv_a, tv_b;
  logic [IW-1:0]     ti_a [RD_LAT];
  logic [IW-1:0]     ti_b [RD_LAT];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == QDEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IW-1:0] rr_inc(input logic [IW-1:0] v);
    return (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      full[i]      = (cnt[i] == CW'(QDEPTH));
      pend[i]      = (cnt[i] != '0);
      starved[i]   = pend[i] && (age[i] == GW'(STARVE_LIMIT));
      push[i]      = req_en[i] && !full[i];
      head_wr[i]   = q_wr[i][rptr[i]];
      head_addr[i] = q_addr[i][rptr[i]];
      head_data[i] = q_data[i][rptr[i]];
    end
  end

  assign req_ready = ~full;

  // Service order: promoted heads first (lowest index), then the static or rotating order.
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) ord[k] = '0;
    pos = '0;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (starved[i]) begin
        ord[pos[IW-1:0]] = IW'(i);
        pos = pos + 1'b1;
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (RR_EN != 0) ? IW'((int'(rr) + int'(k)) % N_REQ) : IW'(k);
      if (!starved[idx]) begin
        ord[pos[IW-1:0]] = idx;
        pos = pos + 1'b1;
      end
    end
  end

  // Port B skips any head that would collide with the port-A head.
  always_comb begin
    ga_v = 1'b0;
    gb_v = 1'b0;
    ga   = '0;
    gb   = '0;
    cur  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cur = ord[k];
      if (pend[cur]) begin
        if (!ga_v) begin
          ga_v = 1'b1;
          ga   = cur;
        end else if (!gb_v && !((head_addr[cur] == head_addr[ga]) &&
                                (head_wr[cur] || head_wr[ga]))) begin
          gb_v = 1'b1;
          gb   = cur;
        end
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++)
      pop[i] = (ga_v && ga == IW'(i)) || (gb_v && gb == IW'(i));
  end

  always_comb begin
    mem_we_a   = ga_v && head_wr[ga];
    mem_addr_a = ga_v ? head_addr[ga] : '0;
    mem_data_a = ga_v ? head_data[ga] : '0;
    mem_we_b   = gb_v && head_wr[gb];
    mem_addr_b = gb_v ? head_addr[gb] : '0;
    mem_data_b = gb_v ? head_data[gb] : '0;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (push[i]) begin
        q_wr[i][wptr[i]]   <= req_wr[i];
        q_addr[i][wptr[i]] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        q_data[i][wptr[i]] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
        age[i]  <= '0;
      end
      rr   <= '0;
      tv_a <= '0;
      tv_b <= '0;
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        ti_a[s] <= '0;
        ti_b[s] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (push[i]) wptr[i] <= ptr_inc(wptr[i]);
        if (pop[i])  rptr[i] <= ptr_inc(rptr[i]);
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
        if (!pend[i] || pop[i]) age[i] <= '0;
        else if (!starved[i])   age[i] <= age[i] + 1'b1;
      end
      if (ga_v) rr <= rr_inc(gb_v ? gb : ga);
      tv_a[0] <= ga_v && !head_wr[ga];
      tv_b[0] <= gb_v && !head_wr[gb];
      ti_a[0] <= ga;
      ti_b[0] <= gb;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        tv_a[s] <= tv_a[s-1];
        tv_b[s] <= tv_b[s-1];
        ti_a[s] <= ti_a[s-1];
        ti_b[s] <= ti_b[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (tv_a[RD_LAT-1] && ti_a[RD_LAT-1] == IW'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q_a;
      end else if (tv_b[RD_LAT-1] && ti_b[RD_LAT-1] == IW'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q_b;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_np.sv
// Bench for mem_arbiter_np: behavioural dual-port SRAM, per-requester drivers,
// and a read-response scoreboard fed from a shadow copy of memory.
module tb_mem_arbiter_np;
  localparam int DW = 32, AW = 16, N = 4, QD = 2, LIM = 8, LAT = 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } tx_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_en, req_wr, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data, rsp_data;
  logic [AW-1:0]   mem_addr_a, mem_addr_b;
  logic [DW-1:0]   mem_data_a, mem_data_b, mem_q_a, mem_q_b;
  logic            mem_we_a, mem_we_b;

  logic [N-1:0]    rr_en, rr_wr, rr_ready, rr_rsp_valid;
  logic [N*AW-1:0] rr_addr;
  logic [N*DW-1:0] rr_data, rr_rsp_data;
  logic [AW-1:0]   rr_mem_addr_a, rr_mem_addr_b;
  logic [DW-1:0]   rr_mem_data_a, rr_mem_data_b;
  logic [DW-1:0]   rr_q_a = '0, rr_q_b = '0;
  logic            rr_we_a, rr_we_b;

  mem_arbiter_np #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N), .QDEPTH(QD),
                   .RR_EN(0), .STARVE_LIMIT(LIM), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
    .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
    .mem_q_a(mem_q_a), .mem_q_b(mem_q_b));

  mem_arbiter_np #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N), .QDEPTH(QD),
                   .RR_EN(1), .STARVE_LIMIT(LIM), .RD_LAT(LAT)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_en(rr_en), .req_wr(rr_wr),
    .req_addr(rr_addr), .req_data(rr_data), .req_ready(rr_ready),
    .rsp_valid(rr_rsp_valid), .rsp_data(rr_rsp_data),
    .mem_addr_a(rr_mem_addr_a), .mem_addr_b(rr_mem_addr_b),
    .mem_data_a(rr_mem_data_a), .mem_data_b(rr_mem_data_b),
    .mem_we_a(rr_we_a), .mem_we_b(rr_we_b),
    .mem_q_a(rr_q_a), .mem_q_b(rr_q_b));

  int tests = 0, fails = 0;
  logic [DW-1:0] sram   [logic [AW-1:0]];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  tx_t           tx_q   [N][$];
  logic [DW-1:0] exp_q  [N][$];
  int acc [N];
  int gnt [N];
  int wt  [N];
  int maxw [N];
  int rsp_seen = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'h0000AAAA;
    if (a == 16'h0020) return 32'h0000BBBB;
    return {16'hC0DE, a};
  endfunction

  function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  function automatic bit busy();
    for (int i = 0; i < N; i++)
      if (tx_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // SRAM model with one cycle of read latency on each port
  always @(posedge clk) begin
    mem_q_a <= sram_rd(mem_addr_a);
    mem_q_b <= sram_rd(mem_addr_b);
    if (mem_we_a) sram[mem_addr_a] = mem_data_a;
    if (mem_we_b) sram[mem_addr_b] = mem_data_b;
  end

  initial begin : driver
    req_en = '0; req_wr = '0; req_addr = '0; req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst_n && tx_q[i].size() > 0) begin
          req_en[i] = 1'b1;
          req_wr[i] = tx_q[i][0].wr;
          req_addr[i*AW +: AW] = tx_q[i][0].addr;
          req_data[i*DW +: DW] = tx_q[i][0].data;
        end else begin
          req_en[i] = 1'b0;
        end
      end
    end
  end

  tx_t acc_t;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) acc[i] = 0;
      else if (req_en[i] && req_ready[i] && tx_q[i].size() > 0) begin
        acc_t = tx_q[i].pop_front();
        if (acc_t.addr[12]) acc[i] = acc[i] + 1;
        if (acc_t.wr) shadow[acc_t.addr] = acc_t.data;
        else exp_q[i].push_back(sh_rd(acc_t.addr));
      end
    end
  end

  initial begin : monitor
    logic [N-1:0]  gm;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin gnt[i] = 0; wt[i] = 0; maxw[i] = 0; end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[i] === 1'b1) begin
            rsp_seen++;
            tests++;
            if (exp_q[i].size() == 0) begin
              fails++;
              $display("FAIL rsp_unexpected req%0d: got data %h, required no response", i, rsp_data[i*DW +: DW]);
            end else begin
              e = exp_q[i].pop_front();
              if (rsp_data[i*DW +: DW] !== e) begin
                fails++;
                $display("FAIL rsp_data req%0d: got %h, required %h", i, rsp_data[i*DW +: DW], e);
              end
            end
          end
        end
        gm = '0;
        if (!mem_we_a && mem_addr_a[12]) gm[mem_addr_a[9:8]] = 1'b1;
        if (!mem_we_b && mem_addr_b[12]) gm[mem_addr_b[9:8]] = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (acc[i] != gnt[i] && !gm[i]) wt[i]++;
          else wt[i] = 0;
          if (wt[i] > maxw[i]) maxw[i] = wt[i];
          if (gm[i]) gnt[i]++;
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int bound);
    int c = 0;
    while (busy() && c < bound) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy()) begin
      fails++;
      $display("FAIL %s_drain: got outstanding work after %0d cycles, required empty", name, bound);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (req_ready !== 4'hF) begin fails++; $display("FAIL reset_ready: got %b, required 1111", req_ready); end
    tests++; if (rsp_valid !== 4'h0) begin fails++; $display("FAIL reset_rsp_valid: got %b, required 0000", rsp_valid); end
    tests++; if ({mem_we_a, mem_we_b} !== 2'b00) begin fails++; $display("FAIL reset_we: got %b, required 00", {mem_we_a, mem_we_b}); end
    tests++; if ({mem_addr_a, mem_addr_b, mem_data_a, mem_data_b} !== '0) begin
      fails++; $display("FAIL reset_mem_bus: got a=%h/%h b=%h/%h, required zero", mem_addr_a, mem_data_a, mem_addr_b, mem_data_b);
    end
    tests++; if (rr_ready !== 4'hF) begin fails++; $display("FAIL reset_rr_ready: got %b, required 1111", rr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parallel_reads();
    @(posedge clk);
    tx_q[0].push_back('{wr: 1'b0, addr: 16'h0010, data: '0});
    tx_q[1].push_back('{wr: 1'b0, addr: 16'h0020, data: '0});
    @(negedge clk);
    @(negedge clk); #1;
    tests++; if (mem_addr_a !== 16'h0010 || mem_addr_b !== 16'h0020 || mem_we_a || mem_we_b) begin
      fails++; $display("FAIL par_issue: got A=%h B=%h we=%b%b, required A=0010 B=0020 we=00", mem_addr_a, mem_addr_b, mem_we_a, mem_we_b);
    end
    @(negedge clk); #1;
    tests++; if (rsp_valid !== 4'b0011) begin fails++; $display("FAIL par_rsp_valid: got %b, required 0011", rsp_valid); end
    tests++; if (rsp_data[DW-1:0] !== 32'h0000AAAA || rsp_data[2*DW-1:DW] !== 32'h0000BBBB) begin
      fails++; $display("FAIL par_rsp_data: got %h %h, required 0000aaaa 0000bbbb", rsp_data[DW-1:0], rsp_data[2*DW-1:DW]);
    end
    wait_drain("par", 20);
  endtask

  task automatic test_collision();
    @(posedge clk);
    tx_q[0].push_back('{wr: 1'b1, addr: 16'h0040, data: 32'h00001234});
    tx_q[1].push_back('{wr: 1'b0, addr: 16'h0040, data: '0});
    @(negedge clk);
    @(negedge clk); #1;
    tests++; if (!(mem_we_a === 1'b1 && mem_addr_a === 16'h0040 && mem_data_a === 32'h00001234)) begin
      fails++; $display("FAIL col_write_a: got we=%b addr=%h data=%h, required 1 0040 00001234", mem_we_a, mem_addr_a, mem_data_a);
    end
    tests++; if (mem_we_b !== 1'b0 || mem_addr_b !== 16'h0000) begin
      fails++; $display("FAIL col_b_withheld: got we=%b addr=%h, required 0 0000", mem_we_b, mem_addr_b);
    end
    @(negedge clk); #1;
    tests++; if (mem_we_a !== 1'b0 || mem_addr_a !== 16'h0040) begin
      fails++; $display("FAIL col_read_next: got we=%b addr=%h, required 0 0040", mem_we_a, mem_addr_a);
    end
    @(negedge clk); #1;
    tests++; if (rsp_valid[1] !== 1'b1 || rsp_data[2*DW-1:DW] !== 32'h00001234) begin
      fails++; $display("FAIL col_read_data: got v=%b d=%h, required 1 00001234", rsp_valid[1], rsp_data[2*DW-1:DW]);
    end
    wait_drain("col", 20);
  endtask

  task automatic test_starvation();
    @(posedge clk);
    for (int n = 0; n < 30; n++)
      for (int i = 0; i < N; i++)
        tx_q[i].push_back('{wr: 1'b0, addr: 16'h1000 | AW'(i << 8) | AW'(n), data: '0});
    wait_drain("starve", 600);
    for (int i = 0; i < N; i++) begin
      tests++; if (maxw[i] > LIM) begin fails++; $display("FAIL starve_wait req%0d: got %0d, required <= %0d", i, maxw[i], LIM); end
      tests++; if (gnt[i] != 30) begin fails++; $display("FAIL starve_grants req%0d: got %0d, required 30", i, gnt[i]); end
    end
    for (int i = 2; i < N; i++) begin
      tests++; if (maxw[i] != LIM) begin fails++; $display("FAIL starve_promote req%0d: got wait %0d, required %0d", i, maxw[i], LIM); end
    end
  endtask

  task automatic test_backpressure();
    int  a0 = acc[3], g0 = gnt[3], cyc = 0;
    bit  s1 = 1'b0, done = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 12; n++)
      for (int i = 0; i < 3; i++)
        tx_q[i].push_back('{wr: 1'b0, addr: 16'h1040 | AW'(i << 8) | AW'(n), data: '0});
    for (int n = 0; n < 3; n++)
      tx_q[3].push_back('{wr: 1'b0, addr: 16'h1360 | AW'(n), data: '0});
    while (!done && cyc < 80) begin
      @(negedge clk); #1;
      cyc++;
      if (!s1 && acc[3] - a0 == 2) begin
        s1 = 1'b1;
        tests++; if (req_ready[3] !== 1'b0) begin fails++; $display("FAIL bp_full: got ready=%b, required 0", req_ready[3]); end
      end
      if (s1 && gnt[3] - g0 == 1) begin
        tests++; if (req_ready[3] !== 1'b0 || acc[3] - a0 != 2) begin
          fails++; $display("FAIL bp_hold: got ready=%b accepts=%0d, required 0 and 2", req_ready[3], acc[3] - a0);
        end
        @(negedge clk); #1;
        tests++; if (req_ready[3] !== 1'b1) begin fails++; $display("FAIL bp_release: got ready=%b, required 1", req_ready[3]); end
        done = 1'b1;
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL bp_timeout: got no pop of requester 3 in %0d cycles, required one", cyc); end
    wait_drain("bp", 200);
  endtask

  task automatic test_round_robin();
    int cnt [N];
    int ia, ib;
    logic [AW-1:0] ea;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    rr_wr = '0; rr_data = '0;
    rr_addr = {16'h0130, 16'h0120, 16'h0110, 16'h0100};
    @(negedge clk);
    rr_en = 4'hF;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      ea = (k % 2 == 0) ? 16'h0100 : 16'h0120;
      tests++; if (rr_mem_addr_a !== ea || rr_mem_addr_b !== ea + 16'h0010) begin
        fails++; $display("FAIL rr_pair cyc%0d: got A=%h B=%h, required A=%h B=%h", k, rr_mem_addr_a, rr_mem_addr_b, ea, ea + 16'h0010);
      end
      ia = (int'(rr_mem_addr_a) - 256) / 16;
      ib = (int'(rr_mem_addr_b) - 256) / 16;
      if (ia >= 0 && ia < N) cnt[ia]++;
      if (ib >= 0 && ib < N) cnt[ib]++;
    end
    rr_en = '0;
    for (int i = 0; i < N; i++) begin
      tests++; if (cnt[i] != 20) begin fails++; $display("FAIL rr_share req%0d: got %0d grants, required 20", i, cnt[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int seen0;
    @(posedge clk);
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 2; n++)
        tx_q[i].push_back('{wr: 1'b0, addr: 16'h0200 | AW'(i << 4) | AW'(n), data: '0});
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin tx_q[i].delete(); exp_q[i].delete(); end
    #1;
    tests++; if (req_ready !== 4'hF) begin fails++; $display("FAIL rmid_ready: got %b, required 1111", req_ready); end
    tests++; if ({mem_we_a, mem_we_b} !== 2'b00) begin fails++; $display("FAIL rmid_we: got %b, required 00", {mem_we_a, mem_we_b}); end
    tests++; if (rsp_valid !== 4'h0) begin fails++; $display("FAIL rmid_rsp: got %b, required 0000", rsp_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen0 = rsp_seen;
    repeat (12) @(negedge clk);
    #1;
    tests++; if (rsp_seen != seen0) begin fails++; $display("FAIL rmid_no_rsp: got %0d responses, required 0", rsp_seen - seen0); end
    tests++; if (mem_addr_a !== 16'h0000 || mem_we_a !== 1'b0) begin
      fails++; $display("FAIL rmid_idle: got addr=%h we=%b, required 0000 0", mem_addr_a, mem_we_a);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion by time limit, required $finish");
    $fatal(1);
  end

  initial begin : main
    rr_en = '0; rr_wr = '0; rr_addr = '0; rr_data = '0;
    test_reset();
    test_parallel_reads();
    test_collision();
    test_starvation();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
